// File: rtl/imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: resolved format
// codes, the RV32/RV64 base opcodes that carry an immediate, and a helper that
// folds the externally supplied format select onto the legal code set.
package imm_gen_pkg;

  // Resolved immediate format codes (out_fmt encoding).
  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_U   = 3'b011;
  localparam logic [2:0] FMT_J   = 3'b100;
  localparam logic [2:0] FMT_ISH = 3'b101;
  localparam logic [2:0] FMT_ILL = 3'b111;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The unused code 110 is treated the same as ILL.
  function automatic logic [2:0] map_ext_fmt(input logic [2:0] sel);
    return (sel == 3'b110) ? FMT_ILL : sel;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational format resolution and immediate extraction. The format comes
// from the opcode (DECODE_MODE=1) or from fmt_sel (DECODE_MODE=0); the
// immediate is sign-extended from bit 31 to XLEN, except shift amounts, which
// are zero-extended.
module imm_fmt_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DECODE_MODE = 1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt_sel,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic [5:0]  shamt;

  // Resolve the immediate format.
  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fmt = FMT_ILL;
    if (DECODE_MODE != 0) begin
      case (instr[6:0])
        OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
        OP_IMM:    fmt = (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) ? FMT_ISH : FMT_I;
        OP_STORE:  fmt = FMT_S;
        OP_BRANCH: fmt = FMT_B;
        OP_LUI, OP_AUIPC: fmt = FMT_U;
        OP_JAL:    fmt = FMT_J;
        default:   fmt = FMT_ILL;
      endcase
    end else begin
      fmt = map_ext_fmt(fmt_sel);
    end
  end

  // Assemble the 32-bit immediate, then extend it to XLEN.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits.
    shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    imm   = (fmt == FMT_ISH) ? XLEN'(shamt) : XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes at the input, stores the resolved
// {imm, fmt, tag} in a 2-entry skid FIFO and presents the head entry.
// Optional feature macro: IMM_GEN_ERR_CHECK_EN adds the sticky err_ill flag
// and the saturating err_cnt counter of illegal pushes.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DECODE_MODE = 1,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ERR_CHECK_EN
  ,
  output logic             err_ill,
  output logic [7:0]       err_cnt
`endif
);

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;

  imm_fmt_decode #(
    .XLEN        (XLEN),
    .DECODE_MODE (DECODE_MODE)
  ) u_decode (
    .instr   (in_instr),
    .fmt_sel (in_fmt),
    .fmt     (dec_fmt),
    .imm     (dec_imm)
  );

  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic       push, pop;

  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic [TAG_W-1:0] tag_q [2];

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state for occupancy and pointers; flush wins over push/pop.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Write the resolved entry at the tail on each accepted push.
  // NOTE: the entry storage is deliberately not reset; an empty FIFO masks
  // it at the outputs, and a write racing a flush stays unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[tail_q] <= dec_imm;
      fmt_q[tail_q] <= dec_fmt;
      tag_q[tail_q] <= in_tag;
    end
  end

  // The head entry only changes on pop, so outputs hold while stalled.
  assign out_imm = out_valid ? imm_q[head_q] : '0;
  assign out_fmt = out_valid ? fmt_q[head_q] : '0;
  assign out_tag = out_valid ? tag_q[head_q] : '0;

`ifdef IMM_GEN_ERR_CHECK_EN
  logic       err_ill_q;
  logic [7:0] err_cnt_q;
  logic       ill_push;

  assign ill_push = push & (dec_fmt == FMT_ILL);

  // Sticky illegal flag and saturating counter; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ill_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (ill_push) begin
      err_ill_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_ill = err_ill_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
